// File: rtl/ofm_wb_pkg.sv
// Shared definitions for the OFM writeback block: error-flag bit positions,
// FSM state encodings and small elaboration-time sizing helpers.
package ofm_wb_pkg;

  // Bit positions inside the sticky err vector {split, orphan_p1, unexpected}
  localparam int ERR_SPLIT  = 2;
  localparam int ERR_ORPHAN = 1;
  localparam int ERR_UNEXP  = 0;

  // Frame FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Address distance between consecutive output channels
  function automatic int ch_stride(input int ofm_h, input int ofm_w);
    return ofm_h * ofm_w;
  endfunction

  // Counter width able to hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_writeback_ofm_requant.sv
// Combinational requantiser: floor arithmetic right shift, optional ReLU,
// then signed saturation into the OUT_W output range.
module ofm_requant
  import ofm_wb_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  input  logic [4:0]       shift,
  input  logic             relu,
  output logic [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-(1 << (OUT_W - 1)));

  logic signed [IN_W-1:0] shifted_s;
  logic signed [IN_W-1:0] clamped_s;

  // Shift, clamp negatives when ReLU is on, then saturate to the output range
  always_comb begin
    shifted_s = $signed(din) >>> shift;
    if (relu && shifted_s[IN_W-1]) begin
      clamped_s = '0;
    end else begin
      clamped_s = shifted_s;
    end
    if (clamped_s > SAT_HI) begin
      dout = SAT_HI[OUT_W-1:0];
    end else if (clamped_s < SAT_LO) begin
      dout = SAT_LO[OUT_W-1:0];
    end else begin
      dout = clamped_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ofm_writeback.sv
// OFM writeback: requantises the conv kernel's two row ports and turns
// tile-ordered beats into raster-order writes on a dual-lane memory port,
// with edge clipping, a start/done handshake and sticky protocol errors.
module ofm_writeback
  import ofm_wb_pkg::*;
#(
  parameter int IN_W    = 25,
  parameter int OUT_W   = 8,
  parameter int TI      = 16,
  parameter int NUM_TW  = 4,
  parameter int GRP_H   = 5,
  parameter int NUM_GRP = 13,
  parameter int NUM_CH  = 8,
  parameter int OFM_W   = 61,
  parameter int OFM_H   = 61,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [IN_W-1:0]   ofm_port0,
  input  logic [IN_W-1:0]   ofm_port1,
  input  logic              ofm_port0_v,
  input  logic              ofm_port1_v,
  output logic              wr0_en,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [OUT_W-1:0]  wr0_data,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [OUT_W-1:0]  wr1_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);

  localparam int OW_W      = cnt_w(TI);
  localparam int TH_W      = cnt_w(GRP_H);
  localparam int TW_W      = cnt_w(NUM_TW);
  localparam int GRP_W     = cnt_w(NUM_GRP);
  localparam int OC_W      = cnt_w(NUM_CH);
  localparam int CH_STRIDE = ch_stride(OFM_H, OFM_W);

  logic [0:0]        state_r;
  logic [OW_W-1:0]   ow_r;
  logic [TH_W-1:0]   th_r;
  logic [TW_W-1:0]   tw_r;
  logic [GRP_W-1:0]  grp_r;
  logic [OC_W-1:0]   oc_r;
  logic [4:0]        shift_r;
  logic              relu_r;
  logic [2:0]        err_r;
  logic              busy_r;
  logic              done_r;
  logic              wr0_en_r;
  logic              wr1_en_r;
  logic [ADDR_W-1:0] wr0_addr_r;
  logic [ADDR_W-1:0] wr1_addr_r;
  logic [OUT_W-1:0]  wr0_data_r;
  logic [OUT_W-1:0]  wr1_data_r;

  logic [OUT_W-1:0]  q0_s;
  logic [OUT_W-1:0]  q1_s;
  logic [31:0]       row_s;
  logic [31:0]       col_s;
  logic [31:0]       base_s;
  logic [31:0]       th_sum_s;
  logic              col_ok_s;
  logic              row0_ok_s;
  logic              row1_ok_s;
  logic              split_s;
  logic              dual_s;
  logic              ow_wrap_s;
  logic              th_wrap_s;
  logic              tw_wrap_s;
  logic              grp_wrap_s;
  logic              last_s;
  logic [OW_W-1:0]   ow_nxt_s;
  logic [TH_W-1:0]   th_nxt_s;
  logic [TW_W-1:0]   tw_nxt_s;
  logic [GRP_W-1:0]  grp_nxt_s;
  logic [OC_W-1:0]   oc_nxt_s;

  ofm_requant #(.IN_W(IN_W), .OUT_W(OUT_W)) u_rq0 (
    .din   (ofm_port0),
    .shift (shift_r),
    .relu  (relu_r),
    .dout  (q0_s)
  );

  ofm_requant #(.IN_W(IN_W), .OUT_W(OUT_W)) u_rq1 (
    .din   (ofm_port1),
    .shift (shift_r),
    .relu  (relu_r),
    .dout  (q1_s)
  );

  // Beat classification, raster address, clipping and next tile position
  always_comb begin
    row_s      = 32'(grp_r) * GRP_H + 32'(th_r);
    col_s      = 32'(tw_r) * TI + 32'(ow_r);
    base_s     = 32'(oc_r) * CH_STRIDE + row_s * OFM_W + col_s;
    col_ok_s   = col_s < OFM_W;
    row0_ok_s  = row_s < OFM_H;
    row1_ok_s  = (row_s + 32'd1) < OFM_H;
    // A dual beat on the group's last row would straddle two groups
    split_s    = ofm_port0_v && ofm_port1_v && (32'(th_r) == GRP_H - 1);
    dual_s     = ofm_port0_v && ofm_port1_v && !split_s;
    ow_wrap_s  = 32'(ow_r) == TI - 1;
    th_sum_s   = 32'(th_r) + (dual_s ? 32'd2 : 32'd1);
    th_wrap_s  = ow_wrap_s && (th_sum_s >= GRP_H);
    tw_wrap_s  = th_wrap_s && (32'(tw_r) == NUM_TW - 1);
    grp_wrap_s = tw_wrap_s && (32'(grp_r) == NUM_GRP - 1);
    last_s     = grp_wrap_s && (32'(oc_r) == NUM_CH - 1);
    ow_nxt_s   = ow_wrap_s ? '0 : ow_r + OW_W'(1);
    th_nxt_s   = th_wrap_s ? '0 : (ow_wrap_s ? TH_W'(th_sum_s) : th_r);
    tw_nxt_s   = th_wrap_s ? (tw_wrap_s ? '0 : tw_r + TW_W'(1)) : tw_r;
    grp_nxt_s  = tw_wrap_s ? (grp_wrap_s ? '0 : grp_r + GRP_W'(1)) : grp_r;
    oc_nxt_s   = grp_wrap_s ? (last_s ? '0 : oc_r + OC_W'(1)) : oc_r;
  end

  // Frame FSM, position counters, sticky errors and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ow_r       <= '0;
      th_r       <= '0;
      tw_r       <= '0;
      grp_r      <= '0;
      oc_r       <= '0;
      shift_r    <= 5'd0;
      relu_r     <= 1'b0;
      err_r      <= 3'b000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr0_en_r   <= 1'b0;
      wr1_en_r   <= 1'b0;
      wr0_addr_r <= '0;
      wr1_addr_r <= '0;
      wr0_data_r <= '0;
      wr1_data_r <= '0;
    end else begin
      wr0_en_r <= 1'b0;
      wr1_en_r <= 1'b0;
      done_r   <= 1'b0;
      if (start) begin
        // (Re)arm: any beat presented alongside start is dropped
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
        ow_r    <= '0;
        th_r    <= '0;
        tw_r    <= '0;
        grp_r   <= '0;
        oc_r    <= '0;
        err_r   <= 3'b000;
        shift_r <= cfg_shift;
        relu_r  <= cfg_relu;
      end else if (state_r == ST_IDLE) begin
        if (ofm_port0_v || ofm_port1_v) begin
          err_r[ERR_UNEXP] <= 1'b1;
        end
      end else if (ofm_port1_v && !ofm_port0_v) begin
        err_r[ERR_ORPHAN] <= 1'b1;
      end else if (ofm_port0_v) begin
        if (split_s) begin
          err_r[ERR_SPLIT] <= 1'b1;
        end
        wr0_en_r   <= col_ok_s && row0_ok_s;
        wr0_addr_r <= ADDR_W'(base_s);
        wr0_data_r <= q0_s;
        wr1_en_r   <= dual_s && col_ok_s && row1_ok_s;
        wr1_addr_r <= ADDR_W'(base_s + OFM_W);
        wr1_data_r <= q1_s;
        ow_r       <= ow_nxt_s;
        th_r       <= th_nxt_s;
        tw_r       <= tw_nxt_s;
        grp_r      <= grp_nxt_s;
        oc_r       <= oc_nxt_s;
        if (last_s) begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
      end
    end
  end

  assign wr0_en   = wr0_en_r;
  assign wr0_addr = wr0_addr_r;
  assign wr0_data = wr0_data_r;
  assign wr1_en   = wr1_en_r;
  assign wr1_addr = wr1_addr_r;
  assign wr1_data = wr1_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_ofm_writeback.sv
// Scoreboard bench for ofm_writeback: the driver computes each cycle's
// expected outputs from a frame-level reference model and queues them; a
// negedge monitor pops and compares against what the DUT presents.
module tb_ofm_writeback;

  localparam int IN_W    = 25;
  localparam int OUT_W   = 8;
  localparam int TI      = 4;
  localparam int NUM_TW  = 2;
  localparam int GRP_H   = 2;
  localparam int NUM_GRP = 2;
  localparam int NUM_CH  = 2;
  localparam int OFM_W   = 7;
  localparam int OFM_H   = 3;
  localparam int ADDR_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic [IN_W-1:0]   ofm_port0;
  logic [IN_W-1:0]   ofm_port1;
  logic              ofm_port0_v;
  logic              ofm_port1_v;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [OUT_W-1:0]  wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [OUT_W-1:0]  wr1_data;
  logic              busy;
  logic              done;
  logic [2:0]        err;

  ofm_writeback #(
    .IN_W(IN_W), .OUT_W(OUT_W), .TI(TI), .NUM_TW(NUM_TW), .GRP_H(GRP_H),
    .NUM_GRP(NUM_GRP), .NUM_CH(NUM_CH), .OFM_W(OFM_W), .OFM_H(OFM_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
    .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    time t;
    bit  chk_all;
    bit  en0;
    int  a0;
    int  d0;
    bit  en1;
    int  a1;
    int  d1;
    bit  done;
    int  err;
    bit  busy;
  } rec_t;

  rec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n_wr  = 0;
  int   n_done = 0;

  // Reference model: position in the frame as pixel/row/tile/group/channel
  bit m_run;
  int m_ow, m_th, m_tw, m_grp, m_oc, m_err, m_sh;
  bit m_rl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic int rq(input int x, input int sh, input bit rl);
    int v;
    v = x >>> sh;
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each queued expectation once its cycle has been clocked
  always @(negedge clk) begin
    rec_t r;
    if (sb.size() > 0 && sb[0].t < $time) begin
      r = sb.pop_front();
      chk("wr0_en", 32'(wr0_en), 32'(r.en0));
      if (r.en0 || r.chk_all) begin
        chk("wr0_addr", 32'(wr0_addr), 32'(r.a0) & 32'hFFFF);
        chk("wr0_data", 32'(wr0_data), 32'(r.d0) & 32'hFF);
      end
      chk("wr1_en", 32'(wr1_en), 32'(r.en1));
      if (r.en1 || r.chk_all) begin
        chk("wr1_addr", 32'(wr1_addr), 32'(r.a1) & 32'hFFFF);
        chk("wr1_data", 32'(wr1_data), 32'(r.d1) & 32'hFF);
      end
      chk("done", 32'(done), 32'(r.done));
      chk("err", 32'(err), 32'(r.err));
      chk("busy", 32'(busy), 32'(r.busy));
    end
    if (wr0_en === 1'b1) n_wr++;
    if (wr1_en === 1'b1) n_wr++;
    if (done === 1'b1) n_done++;
  end

  // Drive one cycle of inputs, predict the outputs that follow it, queue them
  task automatic step(input bit r, input bit s, input bit v0, input bit v1,
                      input int x0, input int x1, input int sh, input bit rl);
    rec_t e;
    bit dual;
    int row, col;
    rst = r; start = s; cfg_shift = 5'(sh); cfg_relu = rl;
    ofm_port0_v = v0; ofm_port1_v = v1;
    ofm_port0 = IN_W'(x0); ofm_port1 = IN_W'(x1);
    e = '{default: 0};
    e.t = $time;
    if (r) begin
      m_run = 0; m_err = 0; m_sh = 0; m_rl = 0;
      m_ow = 0; m_th = 0; m_tw = 0; m_grp = 0; m_oc = 0;
      e.chk_all = 1;
    end else if (s) begin
      m_run = 1; m_err = 0; m_sh = sh; m_rl = rl;
      m_ow = 0; m_th = 0; m_tw = 0; m_grp = 0; m_oc = 0;
    end else if (!m_run) begin
      if (v0 || v1) m_err = m_err | 1;
    end else if (v1 && !v0) begin
      m_err = m_err | 2;
    end else if (v0) begin
      row  = m_grp * GRP_H + m_th;
      col  = m_tw * TI + m_ow;
      dual = v1;
      if (v1 && m_th == GRP_H - 1) begin
        m_err = m_err | 4;
        dual = 0;
      end
      e.en0 = (col < OFM_W) && (row < OFM_H);
      e.a0  = m_oc * OFM_H * OFM_W + row * OFM_W + col;
      e.d0  = rq(x0, m_sh, m_rl);
      e.en1 = dual && (col < OFM_W) && (row + 1 < OFM_H);
      e.a1  = e.a0 + OFM_W;
      e.d1  = rq(x1, m_sh, m_rl);
      m_ow++;
      if (m_ow == TI) begin
        m_ow = 0;
        m_th += dual ? 2 : 1;
        if (m_th >= GRP_H) begin
          m_th = 0;
          m_tw++;
          if (m_tw == NUM_TW) begin
            m_tw = 0;
            m_grp++;
            if (m_grp == NUM_GRP) begin
              m_grp = 0;
              m_oc++;
              if (m_oc == NUM_CH) begin
                m_oc = 0;
                m_run = 0;
                e.done = 1;
              end
            end
          end
        end
      end
    end
    e.err  = m_err;
    e.busy = m_run;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input bit v0, input bit v1, input int x0, input int x1);
    step(0, 0, v0, v1, x0, x1, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  task automatic start_f(input int sh, input bit rl);
    step(0, 1, 0, 0, 0, 0, sh, rl);
  endtask

  function automatic int rnd_pix();
    return int'($urandom) >>> 7;
  endfunction

  initial begin
    int w_snap, d_snap, pick;
    rst = 1; start = 0; cfg_shift = 0; cfg_relu = 0;
    ofm_port0 = 0; ofm_port1 = 0; ofm_port0_v = 0; ofm_port1_v = 0;
    m_run = 0; m_err = 0; m_sh = 0; m_rl = 0;
    m_ow = 0; m_th = 0; m_tw = 0; m_grp = 0; m_oc = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Beat while idle flags unexpected; start clears it
    beat(1, 0, 77, 0);
    idle();
    start_f(2, 0);
    beat(1, 0, 100, 0);
    idle();

    // Dual beat at frame start
    start_f(0, 0);
    beat(1, 1, 5, -3);
    idle();

    // Saturation and ReLU
    start_f(0, 0);
    beat(1, 0, 1000, 0);
    beat(1, 0, -1000, 0);
    start_f(0, 1);
    beat(1, 0, -5, 0);
    idle();

    // Split dual beat on the group's last row, then an orphan port1
    start_f(0, 0);
    for (int i = 0; i < 4; i++) beat(1, 0, i, 0);
    beat(1, 1, 9, 11);
    beat(0, 1, 0, 12);
    idle();

    // Full single-beat frame with clipping; count writes and done pulses
    start_f(1, 0);
    idle();
    #1;
    w_snap = n_wr; d_snap = n_done;
    #1;
    for (int i = 0; i < 64; i++) beat(1, 0, rnd_pix(), 0);
    idle();
    idle();
    #1;
    chk("frame_writes", 32'(n_wr - w_snap), 32'd42);
    chk("frame_done", 32'(n_done - d_snap), 32'd1);
    #1;

    // Restart mid-frame with a beat in the start cycle
    start_f(3, 0);
    for (int i = 0; i < 5; i++) beat(1, 0, rnd_pix(), 0);
    step(0, 1, 1, 1, rnd_pix(), rnd_pix(), 0, 0);
    beat(1, 1, rnd_pix(), rnd_pix());
    idle();

    // Randomised frames mixing single, dual, orphan and idle cycles
    for (int f = 0; f < 4; f++) begin
      start_f(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2000 && m_run; k++) begin
        pick = int'($urandom_range(0, 99));
        if (pick < 15) idle();
        else if (pick < 20) beat(0, 1, 0, rnd_pix());
        else if (pick < 50) beat(1, 1, rnd_pix(), rnd_pix());
        else beat(1, 0, rnd_pix(), 0);
      end
      idle();
    end

    // Reset mid-frame abandons the frame; fresh start restarts at address 0
    start_f(0, 0);
    for (int i = 0; i < 10; i++) beat(1, 0, rnd_pix(), 0);
    #1;
    d_snap = n_done;
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    #1;
    chk("no_done_after_reset", 32'(n_done - d_snap), 32'd0);
    #1;
    start_f(0, 0);
    beat(1, 0, 42, 0);
    idle();
    idle();

    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
